xm_mem_arbiter: RTL
===================

XM_MEM_ARBITER -- requirements
Module: xm_mem_arbiter

Interface
REQ-001 Parameter WORD, default 16: data and address width in bits.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles a granted access waits for ack before aborting.
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 arst_i  in  1  reset, asynchronous and active-low.
REQ-005 en_i[1:0]  in  2  per-port access request pulse; port 0 = CPU controller, port 1 = DMA/debug.
REQ-006 rw_i[1:0]  in  2  per port: 1 = write, 0 = read.
REQ-007 byteOp_i[1:0]  in  2  per port: 1 = byte access, 0 = word access.
REQ-008 adr0_i, adr1_i  in  WORD  per-port byte address.
REQ-009 wdat0_i, wdat1_i  in  WORD  per-port write data; a byte write uses bits 7:0.
REQ-010 busy_o[1:0]  out  2  per port: access accepted and not yet complete.
REQ-011 done_o[1:0]  out  2  per port: one-cycle completion pulse.
REQ-012 err_o[1:0]  out  2  per port: sticky; request dropped or timed out.
REQ-013 rdat_o  out  WORD  read data of the most recent completed read.
REQ-014 memReq_o, memWe_o  out  1,1  memory request and write enable.
REQ-015 memBe_o  out  2  byte-lane enables; bit 0 = bits 7:0, bit 1 = bits 15:8.
REQ-016 memAdr_o, memWdat_o  out  WORD  word-aligned address and lane-placed write data.
REQ-017 memAck_i  in  1  memory completion; read data is valid in the same cycle.
REQ-018 memRdat_i  in  WORD  memory read data.

Function
REQ-019 The block SHALL latch addr, data, rw and byteOp into the per-port pending slot, and set busy_o[p], on the edge where en_i[p]=1 and busy_o[p]=0.
REQ-020 An en_i[p] while busy_o[p]=1 SHALL be dropped without altering the slot, and SHALL set err_o[p].
REQ-021 The FSM SHALL have states IDLE, GRANT0 and GRANT1.
REQ-022 In IDLE with one slot pending, the FSM SHALL move to that port's GRANT state on the next edge.
REQ-023 With both slots pending, the FSM SHALL grant the port not granted last; the last-grant pointer resets to port 1, so port 0 wins the first tie.
REQ-024 A request latched on edge N SHALL become grantable from edge N+1; memReq_o rises no earlier than edge N+1.
REQ-025 In GRANTp the block SHALL hold memReq_o=1 with memAdr_o, memWe_o, memBe_o and memWdat_o stable until memAck_i is sampled.
REQ-026 On the edge sampling memAck_i=1, the block SHALL: return to IDLE; clear busy_o[p]; pulse done_o[p] for exactly one cycle; drop memReq_o.
REQ-027 On a read, the block SHALL register rdat_o on the same edge and hold it until the next read completion.
REQ-028 memAdr_o SHALL be {adr[WORD-1:1],1'b0}.
REQ-029 A word access SHALL drive memBe_o=2'b11 and pass data unchanged; address bit 0 is ignored.
REQ-030 A byte access SHALL drive memBe_o=2'b01 if adr[0]=0, else 2'b10.
REQ-031 A byte write SHALL drive memWdat_o={wdat[7:0],wdat[7:0]}.
REQ-032 A byte read SHALL set rdat_o to the selected lane, zero-extended.
REQ-033 A cycle counter SHALL start at grant; if it reaches TIMEOUT without ack, the block SHALL: return to IDLE; drop memReq_o; clear busy_o[p]; set err_o[p]; assert no done_o; leave rdat_o unchanged.
REQ-034 An en_i[p] in the same cycle as done_o[p]=1 SHALL be accepted, since busy_o[p] is already 0.
REQ-035 Outside a GRANT state, memReq_o and memWe_o SHALL be 0 and memBe_o SHALL be 2'b00.
REQ-036 After an ack, IDLE SHALL last exactly one cycle before the next grant; minimum spacing is 1 idle cycle.

Reset
REQ-037 On arst_i=0, the block SHALL immediately and asynchronously set FSM=IDLE, last-grant=1, counter=0, and clear both slots.
REQ-038 During reset, all outputs SHALL be 0: busy_o, done_o, err_o, rdat_o, memReq_o, memWe_o, memBe_o, memAdr_o, memWdat_o.
REQ-039 An access in flight at reset SHALL be abandoned with no done_o, and a late memAck_i after reset SHALL be ignored in IDLE.

Verification
REQ-040 Port0 word read at 0x0102, ack 2 cycles after memReq_o, memRdat_i=0xBEEF -> memAdr_o=0x0102, memBe_o=11, done_o[0] one cycle, rdat_o=0xBEEF.
REQ-041 Port1 byte write at 0x0011, wdat=0x12A5 -> memAdr_o=0x0010, memBe_o=10, memWdat_o=0xA5A5, memWe_o=1, done_o[1].
REQ-042 Both ports en_i on the same cycle, twice in succession -> grants in order 0,1,0,1 (tie alternates); each grant preceded by one IDLE cycle.
REQ-043 Port0 byte read at 0x0001, memRdat_i=0x7F33 -> rdat_o=0x007F; a second en_i[0] while busy -> err_o[0]=1, slot unchanged.
REQ-044 Ack never arrives, TIMEOUT=4 -> memReq_o drops after 4 granted cycles, err_o set, no done_o, busy_o cleared.
REQ-045 Reset asserted mid-grant, then ack -> memReq_o=0 immediately; no done_o; post-reset request serviced normally.

Source files
------------

// File: rtl/xm_mem_arbiter_if.sv
// Bundle of all request-side and memory-side signals of the two-port memory
// arbiter.
//   slave  : the arbiter's view. It takes the per-port requests and the
//            memory ack/read data, and drives status plus the memory request.
//   master : the environment's view (request sources plus memory), with every
//            direction reversed.
// Signals:
//   en_i/rw_i/byteOp_i          per-port request pulse, write flag, byte flag
//   adr0_i/adr1_i               per-port byte address
//   wdat0_i/wdat1_i             per-port write data
//   busy_o/done_o/err_o/rdat_o  per-port status and last read data
//   memReq_o/memWe_o/memBe_o    memory request, write enable, lane enables
//   memAdr_o/memWdat_o          word-aligned address, lane-placed write data
//   memAck_i/memRdat_i          memory completion and read data
interface xm_mem_arbiter_if #(
    parameter int unsigned WORD = 16
);
    logic [1:0]      en_i;
    logic [1:0]      rw_i;
    logic [1:0]      byteOp_i;
    logic [WORD-1:0] adr0_i;
    logic [WORD-1:0] adr1_i;
    logic [WORD-1:0] wdat0_i;
    logic [WORD-1:0] wdat1_i;
    logic [1:0]      busy_o;
    logic [1:0]      done_o;
    logic [1:0]      err_o;
    logic [WORD-1:0] rdat_o;
    logic            memReq_o;
    logic            memWe_o;
    logic [1:0]      memBe_o;
    logic [WORD-1:0] memAdr_o;
    logic [WORD-1:0] memWdat_o;
    logic            memAck_i;
    logic [WORD-1:0] memRdat_i;

    modport slave (
        input  en_i, rw_i, byteOp_i, adr0_i, adr1_i, wdat0_i, wdat1_i,
        input  memAck_i, memRdat_i,
        output busy_o, done_o, err_o, rdat_o,
        output memReq_o, memWe_o, memBe_o, memAdr_o, memWdat_o
    );

    modport master (
        output en_i, rw_i, byteOp_i, adr0_i, adr1_i, wdat0_i, wdat1_i,
        output memAck_i, memRdat_i,
        input  busy_o, done_o, err_o, rdat_o,
        input  memReq_o, memWe_o, memBe_o, memAdr_o, memWdat_o
    );
endinterface

// File: rtl/xm_mem_arbiter.sv
// Two-port memory arbiter. Port 0 is the CPU controller and port 1 is the
// DMA/debug port. Each port has a single pending slot. A slot is granted the
// single memory interface, with alternating priority on a tie, and the grant
// is held until the memory acks or the timeout expires.
// Ports:
//   clk_i   single clock, rising edge
//   arst_i  asynchronous active-low reset
//   bus     xm_mem_arbiter_if.slave (requests, status, memory bus)
// Parameters:
//   WORD     data/address width; lane logic assumes WORD >= 16
//   TIMEOUT  granted cycles without ack before the access is aborted (>= 1)
module xm_mem_arbiter #(
    parameter int unsigned WORD    = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input logic             clk_i,
    input logic             arst_i,
    xm_mem_arbiter_if.slave bus
);
    localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;  // port granted most recently
    logic [CntW-1:0] cnt_q;
    logic [WORD-1:0] adr_q  [2];
    logic [WORD-1:0] wdat_q [2];
    logic [1:0]      rw_q, byte_q, busy_q, done_q, err_q;
    logic [WORD-1:0] rdat_q;

    logic            granted, sel, ack, timeout;
    logic [7:0]      rd_lane;
    logic            mem_req, mem_we;
    logic [1:0]      mem_be;
    logic [WORD-1:0] mem_adr, mem_wdat;

    assign granted = (state_q != StIdle);
    assign sel     = (state_q == StGrant1);
    assign ack     = granted & bus.memAck_i;
    // Ack wins over timeout when both land on the last allowed cycle.
    assign timeout = granted & ~bus.memAck_i & (cnt_q == CntLast);
    assign rd_lane = adr_q[sel][0] ? bus.memRdat_i[15:8] : bus.memRdat_i[7:0];

    // State register
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next state: a pending slot is just a busy one, since busy only clears
    // on the edge that finishes the access.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (busy_q[0] && (!busy_q[1] || last_q)) begin
                    state_d = StGrant0;
                    last_d  = 1'b0;
                end else if (busy_q[1]) begin
                    state_d = StGrant1;
                    last_d  = 1'b1;
                end
            end
            StGrant0, StGrant1: begin
                if (ack || timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side outputs, driven only while granted
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_be   = 2'b00;
        mem_adr  = '0;
        mem_wdat = '0;
        if (granted) begin
            mem_req  = 1'b1;
            mem_we   = rw_q[sel];
            mem_adr  = {adr_q[sel][WORD-1:1], 1'b0};
            mem_wdat = wdat_q[sel];
            if (byte_q[sel]) begin
                mem_be         = adr_q[sel][0] ? 2'b10 : 2'b01;
                mem_wdat[15:8] = wdat_q[sel][7:0];
            end else begin
                mem_be = 2'b11;
            end
        end
    end

    // Slots, status flags, timeout counter and read data
    always_ff @(posedge clk_i or negedge arst_i) begin
        if (!arst_i) begin
            cnt_q  <= '0;
            rw_q   <= 2'b00;
            byte_q <= 2'b00;
            busy_q <= 2'b00;
            done_q <= 2'b00;
            err_q  <= 2'b00;
            rdat_q <= '0;
            for (int p = 0; p < 2; p++) begin
                adr_q[p]  <= '0;
                wdat_q[p] <= '0;
            end
        end else begin
            done_q <= 2'b00;
            if (!granted || ack || timeout) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
            // A request to a busy port is dropped and flagged; the slot keeps
            // the access already in flight.
            for (int p = 0; p < 2; p++) begin
                if (bus.en_i[p]) begin
                    if (busy_q[p]) begin
                        err_q[p] <= 1'b1;
                    end else begin
                        adr_q[p]  <= (p == 0) ? bus.adr0_i : bus.adr1_i;
                        wdat_q[p] <= (p == 0) ? bus.wdat0_i : bus.wdat1_i;
                        rw_q[p]   <= bus.rw_i[p];
                        byte_q[p] <= bus.byteOp_i[p];
                        busy_q[p] <= 1'b1;
                    end
                end
            end
            if (ack || timeout) begin
                busy_q[sel] <= 1'b0;
            end
            if (ack) begin
                done_q[sel] <= 1'b1;
                if (!rw_q[sel]) begin
                    rdat_q <= byte_q[sel] ? {{(WORD-8){1'b0}}, rd_lane} : bus.memRdat_i;
                end
            end
            if (timeout) begin
                err_q[sel] <= 1'b1;
            end
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.rdat_o    = rdat_q;
    assign bus.memReq_o  = mem_req;
    assign bus.memWe_o   = mem_we;
    assign bus.memBe_o   = mem_be;
    assign bus.memAdr_o  = mem_adr;
    assign bus.memWdat_o = mem_wdat;
endmodule
